// File: rtl/lsu_controller.sv
// Load/store unit controller.
// Accepts one RV32I load or store at a time, checks alignment and width
// code, and drives a word-wide memory port that has no byte enables.
// Sub-word stores are done as read-modify-write; loads are byte/half
// extracted and sign- or zero-extended before the completion pulse.
module lsu_controller #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  // response side
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Controller states.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // RV32I width codes.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  // Holds the raw read word for loads, the merged word for sub-word stores.
  logic [31:0]       word_q;

  logic              accept;
  logic              req_bad;

  // Width code legality and natural alignment of the incoming request.
  function automatic logic is_bad(input logic       wr,
                                  input logic [2:0] f3,
                                  input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:         bad = 1'b0;
      F3_H:         bad = off[0];
      F3_W:         bad = (off != 2'b00);
      F3_BU:        bad = wr;
      F3_HU:        bad = wr | off[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace only the addressed byte or half of the word read from memory.
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  off,
                                        input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (f3 == F3_B) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (f3 == F3_H) begin
      if (off[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  // Select the addressed byte or half and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign req_bad = is_bad(req_write, req_funct3, req_addr[1:0]);

  // Next-state selection.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)                              state_d = S_RESP;
          else if (req_write && req_funct3 == F3_W) state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = write_q ? S_WR : S_RESP;
      S_WR:      state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register, request latch and read-word capture.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request and captured word are cleared too, so an
      // aborted transaction leaves nothing behind that could leak out later.
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      word_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_bad;
      end
      if (state_q == S_RD_WAIT) begin
        word_q <= write_q ? merge(mem_rdata, funct3_q, addr_q[1:0], wdata_q)
                          : mem_rdata;
      end
    end
  end

  // Moore output decode from state and latched request only.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && err_q;
    rsp_rdata = 32'd0;
    if ((state_q == S_RESP) && !err_q && !write_q)
      rsp_rdata = extract(word_q, funct3_q, addr_q[1:0]);
    mem_re    = (state_q == S_RD);
    mem_we    = (state_q == S_WR);
    mem_addr  = '0;
    if ((state_q == S_RD) || (state_q == S_WR))
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata = 32'd0;
    if (state_q == S_WR)
      mem_wdata = (funct3_q == F3_W) ? wdata_q : word_q;
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: a table of single transactions
// against a simple word memory, plus hand-written reset and back-to-back
// sequences.
module tb_lsu_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_controller #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory with one-cycle read latency, plus a preload port for the bench.
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  // Memory model.
  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_re)      mem_rdata <= mem[mem_addr[11:2]];
  end

  // Free-running event counters and interface-rule watchers.
  int cyc = 0, re_cnt = 0, we_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
  int ovl = 0, viol = 0;
  int acc_cyc [0:15];

  // Interface monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re && mem_we) ovl <= ovl + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (!rst && req_valid && req_ready) begin
      acc_cyc[acc_cnt % 16] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if ((!rsp_valid && (rsp_rdata != 0 || rsp_err)) ||
        (!mem_we && mem_wdata != 0) ||
        (!mem_re && !mem_we && mem_addr != 0))
      viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a[11:2]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_word;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Apply one table entry and compare every observable effect.
  task automatic run_vec(input int i);
    vec_t v;
    int   lat, re0, we0;
    string n;
    v = vecs[i];
    n = $sformatf("vec%0d", i);
    preload(v.addr, v.init);
    re0 = re_cnt; we0 = we_cnt;
    check({n, " ready"}, {31'd0, req_ready}, 32'd1);
    drive(v.wr, v.f3, v.addr, v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({n, " latency"}, lat, v.exp_lat);
    check({n, " rdata"}, rsp_rdata, v.exp_rdata);
    check({n, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
    check({n, " mem_re count"}, re_cnt - re0, v.exp_re);
    check({n, " mem_we count"}, we_cnt - we0, v.exp_we);
    check({n, " mem word"}, mem[v.addr[11:2]], v.exp_word);
    @(negedge clk);
  endtask

  int r0, w0, a0, b;

  initial begin
    //            wr    f3    addr      wdata          init           rdata          err   word           lat re we
    vecs[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,         32'h807060F0, 32'hFFFFFF80, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[1]  = '{1'b0, 3'd4, 32'h100, 32'h0,         32'h807060F0, 32'h000000F0, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[2]  = '{1'b0, 3'd1, 32'h102, 32'h0,         32'h807060F0, 32'hFFFF8070, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[3]  = '{1'b0, 3'd5, 32'h102, 32'h0,         32'h807060F0, 32'h00008070, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[4]  = '{1'b0, 3'd2, 32'h100, 32'h0,         32'h807060F0, 32'h807060F0, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[5]  = '{1'b0, 3'd0, 32'h101, 32'h0,         32'h807060F0, 32'h00000060, 1'b0, 32'h807060F0, 3, 1, 0};
    vecs[6]  = '{1'b1, 3'd0, 32'h101, 32'h000000AA,  32'h11223344, 32'h0,        1'b0, 32'h1122AA44, 4, 1, 1};
    vecs[7]  = '{1'b1, 3'd2, 32'h200, 32'hDEADBEEF,  32'h00000000, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 1};
    vecs[8]  = '{1'b1, 3'd1, 32'h102, 32'h0000BEEF,  32'h11223344, 32'h0,        1'b0, 32'hBEEF3344, 4, 1, 1};
    vecs[9]  = '{1'b0, 3'd2, 32'h202, 32'h0,         32'h12345678, 32'h0,        1'b1, 32'h12345678, 1, 0, 0};
    vecs[10] = '{1'b1, 3'd1, 32'h001, 32'h0000FFFF,  32'hCAFEF00D, 32'h0,        1'b1, 32'hCAFEF00D, 1, 0, 0};
    vecs[11] = '{1'b0, 3'd3, 32'h100, 32'h0,         32'h807060F0, 32'h0,        1'b1, 32'h807060F0, 1, 0, 0};
    vecs[12] = '{1'b1, 3'd4, 32'h100, 32'h00000011,  32'h807060F0, 32'h0,        1'b1, 32'h807060F0, 1, 0, 0};
    vecs[13] = '{1'b0, 3'd1, 32'h101, 32'h0,         32'h807060F0, 32'h0,        1'b1, 32'h807060F0, 1, 0, 0};

    // Reset with a request pending: nothing may be accepted.
    rst = 1'b1;
    drive(1'b0, 3'd2, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    r0 = rsp_cnt;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset mem_re", {31'd0, mem_re}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset no accept", acc_cnt, 0);
    repeat (4) @(negedge clk);
    check("reset no rsp", rsp_cnt - r0, 0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset during RD_WAIT of an SB: the pending merge must never be written.
    preload(32'h300, 32'h11223344);
    w0 = we_cnt; r0 = rsp_cnt;
    drive(1'b1, 3'd0, 32'h301, 32'h00000055);
    @(negedge clk);              // +1 RD
    req_valid = 1'b0;
    @(negedge clk);              // +2 RD_WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rmw abort mem_we count", we_cnt - w0, 0);
    check("rmw abort rsp count", rsp_cnt - r0, 0);
    check("rmw abort mem word", mem[10'h300 >> 2], 32'h11223344);
    check("rmw abort req_ready", {31'd0, req_ready}, 32'd1);

    // Reset during WR of an SH: strobe drops on the reset edge, no response.
    preload(32'h304, 32'hA5A5A5A5);
    w0 = we_cnt; r0 = rsp_cnt;
    drive(1'b1, 3'd1, 32'h306, 32'h0000BEEF);
    @(negedge clk);              // +1 RD
    req_valid = 1'b0;
    @(negedge clk);              // +2 RD_WAIT
    @(negedge clk);              // +3 WR
    check("wr abort mem_we before", {31'd0, mem_we}, 32'd1);
    check("wr abort merged wdata", mem_wdata, 32'hBEEFA5A5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("wr abort mem_we after", {31'd0, mem_we}, 32'd0);
    check("wr abort req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("wr abort rsp count", rsp_cnt - r0, 0);
    check("wr abort mem_we count", we_cnt - w0, 1);

    // req_valid held across three loads: accepted every fourth cycle.
    preload(32'h100, 32'h807060F0);
    a0 = acc_cnt; r0 = rsp_cnt;
    drive(1'b0, 3'd2, 32'h100, 32'h0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 3) break;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b accept count", acc_cnt - a0, 3);
    check("b2b rsp count", rsp_cnt - r0, 3);
    b = a0 % 16;
    check("b2b gap 1", acc_cyc[(b + 1) % 16] - acc_cyc[b], 4);
    check("b2b gap 2", acc_cyc[(b + 2) % 16] - acc_cyc[(b + 1) % 16], 4);

    check("strobe overlap", ovl, 0);
    check("idle output rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0 B, 1 H, 2 W (stores).
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 rsp_err  output  1  valid with rsp_valid; request misaligned or illegal funct3.
REQ-013 mem_addr  output  ADDR_W  word address to memory; bits [1:0] always 0.
REQ-014 mem_re  output  1  memory read strobe.
REQ-015 mem_we  output  1  memory full-word write strobe; memory has no byte enables.
REQ-016 mem_wdata  output  32  write word.
REQ-017 mem_rdata  input  32  read word; valid exactly one cycle after the mem_re cycle.

Function
REQ-018 States: IDLE, RD, RD_WAIT, WR, RESP; Moore outputs decoded from state and latched request registers only.
REQ-019 req_ready = 1 only in IDLE; request accepted on an edge where state is IDLE and req_valid = 1; write, funct3, addr and wdata latched at acceptance.
REQ-020 Acceptance check: illegal funct3 (3, 6, 7; or 4, 5 with req_write = 1) -> error; H/HU with addr[0] = 1 -> error; W with addr[1:0] != 0 -> error.
REQ-021 Error path: IDLE -> RESP; rsp_err = 1, rsp_rdata = 0; no mem_re or mem_we issued.
REQ-022 Load path: IDLE -> RD (mem_re = 1) -> RD_WAIT (capture mem_rdata) -> RESP; rsp_valid 3 cycles after acceptance.
REQ-023 SW path: IDLE -> WR (mem_we = 1, mem_wdata = req_wdata) -> RESP; rsp_valid 2 cycles after acceptance.
REQ-024 SB/SH path: IDLE -> RD -> RD_WAIT (merge) -> WR -> RESP; rsp_valid 4 cycles after acceptance; memory word replaced only in the addressed byte or half.
REQ-025 Merge: SB replaces byte addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; other bits unchanged from the read word.
REQ-026 Load extraction: byte selected by addr[1:0], half by addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-027 mem_addr = {latched addr[ADDR_W-1:2], 2'b00} in RD and WR; 0 in all other states.
REQ-028 mem_re = 1 only in RD; mem_we = 1 only in WR; never both in the same cycle.
REQ-029 mem_wdata = 0 outside WR.
REQ-030 RESP lasts exactly 1 cycle, then IDLE; rsp_valid has no back-pressure.
REQ-031 rsp_rdata and rsp_err = 0 whenever rsp_valid = 0.
REQ-032 Back-to-back: the earliest next acceptance is the cycle after RESP; req_valid held during busy states is ignored, not queued.

Reset
REQ-033 rst = 1 on an edge -> state IDLE; latched request, captured read data and all outputs cleared.
REQ-034 Post-reset outputs: req_ready = 1; rsp_valid, rsp_err, mem_re, mem_we = 0; rsp_rdata, mem_addr, mem_wdata = 0.
REQ-035 Reset mid-operation aborts the transaction: no later mem_we, no rsp_valid for it; a pending SB/SH RMW performs no write.
REQ-036 req_valid on a cycle with rst = 1 is not accepted.

Verification
REQ-037 Memory word 0x100 = 0x8070_60F0; LB at 0x103 -> rsp_rdata = 0xFFFF_FF80 at +3; LBU at 0x100 -> 0x0000_00F0; LH at 0x102 -> 0xFFFF_8070.
REQ-038 SB wdata 0x0000_00AA to 0x101 over word 0x1122_3344 -> one mem_re, one mem_we with 0x1122_AA44 at +3; rsp_valid at +4.
REQ-039 SW 0xDEAD_BEEF to 0x200 -> mem_we with mem_addr 0x200 at +1; no mem_re; rsp_valid, rsp_err = 0 at +2.
REQ-040 LW at 0x202, then SH at 0x001, then funct3 = 3 -> each gives rsp_err = 1 at +1 with no memory strobes.
REQ-041 rst asserted in the WR state of an SH -> mem_we deasserts on the same edge; no rsp_valid; req_ready = 1 the cycle after.
REQ-042 req_valid held high continuously across 3 loads -> exactly 3 accepted, acceptances 4 cycles apart, mem_re never overlapping mem_we.
